// File: rtl/cmd_seq_if.sv
// Handshake bundle between UART_wrapper, cmd_sequencer and cmd_proc.
// The master modport is the sequencer's view; slave is the surrounding logic.
interface cmd_seq_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [15:0]   host_cmd;
  logic          host_vld;
  logic          host_clr;
  logic [15:0]   cmd;
  logic          cmd_rdy;
  logic          clr_cmd_rdy;
  logic          done;
  logic          abort;
  logic [7:0]    resp;
  logic          send_resp;
  logic          busy;
  logic [CW-1:0] q_cnt;
  logic          q_full;

  modport master (
    input  host_cmd, host_vld, clr_cmd_rdy, done, abort,
    output host_clr, cmd, cmd_rdy, resp, send_resp, busy, q_cnt, q_full
  );

  modport slave (
    output host_cmd, host_vld, clr_cmd_rdy, done, abort,
    input  host_clr, cmd, cmd_rdy, resp, send_resp, busy, q_cnt, q_full
  );
endinterface

// File: rtl/cmd_sequencer.sv
// Queues Knight commands from the host and issues them one at a time to cmd_proc.
// Optional watchdog abort in WAIT_DONE is enabled by defining CMD_SEQ_TIMEOUT_EN.
module cmd_sequencer #(
  parameter int DEPTH      = 8,
  parameter int TMO_CYCLES = 2**26
) (
  input  logic       clk,
  input  logic       rst_n,
  cmd_seq_if.master  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [7:0] RESP_OK    = 8'hA5;
  localparam logic [7:0] RESP_ABORT = 8'h5A;
  localparam logic [7:0] RESP_TMO   = 8'hEE;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("cmd_sequencer: DEPTH must be a power of 2 and >= 2");
  end
  if (TMO_CYCLES < 2) begin : g_bad_tmo
    $error("cmd_sequencer: TMO_CYCLES must be >= 2");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_DONE,
    S_RESP
  } state_t;

  state_t         state_q, state_d;
  logic [15:0]    cmd_q, cmd_d;
  logic           cmd_rdy_q, cmd_rdy_d;
  logic [7:0]     resp_q, resp_d;
  logic           send_resp_q, send_resp_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [15:0]    mem_q [DEPTH];

  logic           full;
  logic           push;
  logic           pop;
  logic           kill;
  logic           tmo_fire;

  assign full = (cnt_q == CW'(DEPTH));
  assign kill = bus.abort | tmo_fire;
  // A push is refused while full even if a pop happens this cycle, and never survives a flush.
  assign push = rst_n & bus.host_vld & ~full & ~kill;

`ifdef CMD_SEQ_TIMEOUT_EN
  localparam logic [31:0] TMO_LAST = 32'(TMO_CYCLES - 1);

  logic [31:0] tmo_cnt_q, tmo_cnt_d;

  always_comb begin
    tmo_cnt_d = '0;
    if (state_q == S_WAIT_DONE) begin
      tmo_cnt_d = tmo_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  // A done arriving on the last counted cycle still completes normally.
  assign tmo_fire = (state_q == S_WAIT_DONE) && (tmo_cnt_q == TMO_LAST) && !bus.done;
`else
  assign tmo_fire = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    cmd_rdy_d   = cmd_rdy_q;
    resp_d      = resp_q;
    send_resp_d = 1'b0;
    pop         = 1'b0;

    if (kill) begin
      cmd_rdy_d = 1'b0;
      if ((state_q == S_ISSUE) || (state_q == S_WAIT_DONE)) begin
        state_d     = S_RESP;
        resp_d      = bus.abort ? RESP_ABORT : RESP_TMO;
        send_resp_d = 1'b1;
      end else begin
        state_d = S_IDLE;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cnt_q != '0) begin
            cmd_d     = mem_q[rd_ptr_q];
            cmd_rdy_d = 1'b1;
            state_d   = S_ISSUE;
          end
        end
        S_ISSUE: begin
          // The entry stays queued until cmd_proc acknowledges it.
          if (bus.clr_cmd_rdy) begin
            pop       = 1'b1;
            cmd_rdy_d = 1'b0;
            state_d   = S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (bus.done) begin
            resp_d      = RESP_OK;
            send_resp_d = 1'b1;
            state_d     = S_RESP;
          end
        end
        S_RESP: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (kill) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cmd_q       <= '0;
      cmd_rdy_q   <= 1'b0;
      resp_q      <= '0;
      send_resp_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      cmd_rdy_q   <= cmd_rdy_d;
      resp_q      <= resp_d;
      send_resp_q <= send_resp_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
    end
  end

  // Storage is not reset; validity is tracked by the pointers and count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.host_cmd;
    end
  end

  assign bus.host_clr  = push;
  assign bus.cmd       = cmd_q;
  assign bus.cmd_rdy   = cmd_rdy_q;
  assign bus.resp      = resp_q;
  assign bus.send_resp = send_resp_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.q_cnt     = cnt_q;
  assign bus.q_full    = full;

endmodule

// File: tb/tb_cmd_sequencer.sv
// Directed bench for cmd_sequencer: reset, single command, full queue, push/pop, wrap, abort, reset, timeout.
module tb_cmd_sequencer;
  localparam int DEPTH = 8;
  localparam int TMO   = 1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cmd_seq_if #(.DEPTH(DEPTH)) bus ();

  cmd_sequencer #(.DEPTH(DEPTH), .TMO_CYCLES(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.host_cmd    = 16'h0000;
    bus.host_vld    = 1'b0;
    bus.clr_cmd_rdy = 1'b0;
    bus.done        = 1'b0;
    bus.abort       = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic push_cmd(input logic [15:0] c, output bit ok);
    ok = 1'b0;
    bus.host_cmd = c;
    bus.host_vld = 1'b1;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (bus.host_clr) begin
        ok = 1'b1;
        tick();
        break;
      end
      tick();
    end
    bus.host_vld = 1'b0;
  endtask

  task automatic wait_rdy(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.cmd_rdy) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Plays cmd_proc for one command: ack, done, then back to IDLE.
  task automatic serve(output logic [15:0] got, output bit ok, output logic sr, output logic [7:0] rv);
    got = 16'h0000;
    sr  = 1'b0;
    rv  = 8'h00;
    wait_rdy(ok);
    if (ok) begin
      got = bus.cmd;
      bus.clr_cmd_rdy = 1'b1;
      tick();
      bus.clr_cmd_rdy = 1'b0;
      bus.done = 1'b1;
      tick();
      bus.done = 1'b0;
      sr = bus.send_resp;
      rv = bus.resp;
      tick();
    end
  endtask

  task automatic test_reset();
    int bad;
    bad = 0;
    do_reset();
    for (int i = 0; i < 100; i++) begin
      checks++;
      if (bus.cmd_rdy !== 1'b0 || bus.send_resp !== 1'b0 || bus.q_cnt !== 0 || bus.busy !== 1'b0 ||
          bus.cmd !== 16'h0000 || bus.resp !== 8'h00 || bus.q_full !== 1'b0 || bus.host_clr !== 1'b0) begin
        errors++;
        if (bad < 3)
          $display("FAIL reset_idle cyc %0d: rdy=%b sr=%b cnt=%0d busy=%b cmd=%h resp=%h full=%b clr=%b, expected all zero",
                   i, bus.cmd_rdy, bus.send_resp, bus.q_cnt, bus.busy, bus.cmd, bus.resp, bus.q_full, bus.host_clr);
        bad++;
      end
      tick();
    end
  endtask

  task automatic test_single();
    bit ok;
    int pulses;
    do_reset();
    push_cmd(16'h4BF1, ok);
    checks++;
    if (!ok || bus.q_cnt !== 1) begin
      errors++; $display("FAIL single_push: ok=%b q_cnt=%0d, expected ok=1 q_cnt=1", ok, bus.q_cnt);
    end
    tick();
    checks++;
    if (bus.cmd_rdy !== 1'b1 || bus.cmd !== 16'h4BF1) begin
      errors++; $display("FAIL single_issue: rdy=%b cmd=%h, expected 1 4bf1", bus.cmd_rdy, bus.cmd);
    end
    repeat (4) tick();
    checks++;
    if (bus.cmd_rdy !== 1'b1 || bus.cmd !== 16'h4BF1 || bus.q_cnt !== 1) begin
      errors++; $display("FAIL single_hold: rdy=%b cmd=%h cnt=%0d, expected 1 4bf1 1", bus.cmd_rdy, bus.cmd, bus.q_cnt);
    end
    bus.clr_cmd_rdy = 1'b1;
    tick();
    bus.clr_cmd_rdy = 1'b0;
    checks++;
    if (bus.cmd_rdy !== 1'b0 || bus.q_cnt !== 0 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL single_ack: rdy=%b cnt=%0d busy=%b, expected 0 0 1", bus.cmd_rdy, bus.q_cnt, bus.busy);
    end
    pulses = 0;
    for (int i = 0; i < 200; i++) begin
      if (bus.send_resp) pulses++;
      tick();
    end
    checks++;
    if (pulses != 0) begin
      errors++; $display("FAIL single_early_resp: pulses=%0d, expected 0", pulses);
    end
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    checks++;
    if (bus.send_resp !== 1'b1 || bus.resp !== 8'hA5) begin
      errors++; $display("FAIL single_resp: sr=%b resp=%h, expected 1 a5", bus.send_resp, bus.resp);
    end
    tick();
    checks++;
    if (bus.send_resp !== 1'b0 || bus.busy !== 1'b0 || bus.q_cnt !== 0) begin
      errors++; $display("FAIL single_end: sr=%b busy=%b cnt=%0d, expected 0 0 0", bus.send_resp, bus.busy, bus.q_cnt);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int n, stalls;
    logic [15:0] got;
    logic sr;
    logic [7:0] rv;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      push_cmd(16'h1000 + 16'(i), ok);
      checks++;
      if (!ok) begin
        errors++; $display("FAIL b2b_push%0d: not accepted, expected accepted", i);
      end
    end
    checks++;
    if (bus.q_full !== 1'b1 || bus.q_cnt !== 8) begin
      errors++; $display("FAIL b2b_full: full=%b cnt=%0d, expected 1 8", bus.q_full, bus.q_cnt);
    end
    bus.host_cmd = 16'h1008;
    bus.host_vld = 1'b1;
    stalls = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (bus.host_clr) stalls++;
      tick();
    end
    checks++;
    if (stalls != 0 || bus.q_cnt !== 8) begin
      errors++; $display("FAIL b2b_stall: host_clr seen %0d times cnt=%0d, expected 0 and 8", stalls, bus.q_cnt);
    end
    checks++;
    if (bus.cmd_rdy !== 1'b1 || bus.cmd !== 16'h1000) begin
      errors++; $display("FAIL b2b_first: rdy=%b cmd=%h, expected 1 1000", bus.cmd_rdy, bus.cmd);
    end
    bus.clr_cmd_rdy = 1'b1;
    #1;
    checks++;
    if (bus.host_clr !== 1'b0) begin
      errors++; $display("FAIL b2b_full_pop: host_clr=%b, expected 0", bus.host_clr);
    end
    tick();
    bus.clr_cmd_rdy = 1'b0;
    checks++;
    if (bus.host_clr !== 1'b1 || bus.q_cnt !== 7) begin
      errors++; $display("FAIL b2b_ninth: host_clr=%b cnt=%0d, expected 1 7", bus.host_clr, bus.q_cnt);
    end
    tick();
    bus.host_vld = 1'b0;
    checks++;
    if (bus.q_cnt !== 8) begin
      errors++; $display("FAIL b2b_refill: cnt=%0d, expected 8", bus.q_cnt);
    end
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    n = 1;
    while (!bus.cmd_rdy && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (n != 3) begin
      errors++; $display("FAIL b2b_spacing: cmd_rdy %0d cycles after done, expected 3", n);
    end
    for (int i = 1; i <= 8; i++) begin
      serve(got, ok, sr, rv);
      checks++;
      if (!ok || got !== 16'h1000 + 16'(i) || sr !== 1'b1 || rv !== 8'hA5) begin
        errors++; $display("FAIL b2b_order%0d: ok=%b cmd=%h sr=%b resp=%h, expected 1 %h 1 a5", i, ok, got, sr, rv, 16'h1000 + 16'(i));
      end
    end
  endtask

  task automatic test_push_pop_wrap();
    bit ok;
    logic [15:0] got;
    logic sr;
    logic [7:0] rv;
    do_reset();
    for (int i = 0; i < 3; i++) push_cmd(16'h2000 + 16'(i), ok);
    checks++;
    if (bus.q_cnt !== 3 || bus.cmd_rdy !== 1'b1 || bus.cmd !== 16'h2000) begin
      errors++; $display("FAIL pp_setup: cnt=%0d rdy=%b cmd=%h, expected 3 1 2000", bus.q_cnt, bus.cmd_rdy, bus.cmd);
    end
    bus.host_cmd = 16'h2003;
    bus.host_vld = 1'b1;
    bus.clr_cmd_rdy = 1'b1;
    #1;
    checks++;
    if (bus.host_clr !== 1'b1) begin
      errors++; $display("FAIL pp_accept: host_clr=%b, expected 1", bus.host_clr);
    end
    tick();
    bus.host_vld = 1'b0;
    bus.clr_cmd_rdy = 1'b0;
    checks++;
    if (bus.q_cnt !== 3) begin
      errors++; $display("FAIL pp_count: cnt=%0d, expected 3", bus.q_cnt);
    end
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    tick();
    for (int i = 1; i <= 3; i++) begin
      serve(got, ok, sr, rv);
      checks++;
      if (!ok || got !== 16'h2000 + 16'(i)) begin
        errors++; $display("FAIL pp_order%0d: ok=%b cmd=%h, expected 1 %h", i, ok, got, 16'h2000 + 16'(i));
      end
    end
    for (int b = 0; b < 5; b++) begin
      for (int j = 0; j < 4; j++) push_cmd(16'h3000 + 16'(b * 4 + j), ok);
      for (int j = 0; j < 4; j++) begin
        serve(got, ok, sr, rv);
        checks++;
        if (!ok || got !== 16'h3000 + 16'(b * 4 + j)) begin
          errors++; $display("FAIL wrap_order%0d: ok=%b cmd=%h, expected 1 %h", b * 4 + j, ok, got, 16'h3000 + 16'(b * 4 + j));
        end
      end
    end
    checks++;
    if (bus.q_cnt !== 0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL wrap_end: cnt=%0d busy=%b, expected 0 0", bus.q_cnt, bus.busy);
    end
  endtask

  task automatic test_abort();
    bit ok;
    int pulses;
    logic [15:0] got;
    logic sr;
    logic [7:0] rv;
    do_reset();
    for (int i = 0; i < 5; i++) push_cmd(16'h4000 + 16'(i), ok);
    wait_rdy(ok);
    bus.clr_cmd_rdy = 1'b1;
    tick();
    bus.clr_cmd_rdy = 1'b0;
    checks++;
    if (!ok || bus.q_cnt !== 4 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL abort_setup: ok=%b cnt=%0d busy=%b, expected 1 4 1", ok, bus.q_cnt, bus.busy);
    end
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    checks++;
    if (bus.q_cnt !== 0 || bus.send_resp !== 1'b1 || bus.resp !== 8'h5A || bus.cmd_rdy !== 1'b0) begin
      errors++; $display("FAIL abort_resp: cnt=%0d sr=%b resp=%h rdy=%b, expected 0 1 5a 0", bus.q_cnt, bus.send_resp, bus.resp, bus.cmd_rdy);
    end
    tick();
    checks++;
    if (bus.send_resp !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL abort_idle: sr=%b busy=%b, expected 0 0", bus.send_resp, bus.busy);
    end
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    pulses = (bus.send_resp || bus.cmd_rdy) ? 1 : 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.send_resp || bus.cmd_rdy) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++; $display("FAIL abort_late_done: activity=%0d, expected 0", pulses);
    end
    bus.host_cmd = 16'h4444;
    bus.host_vld = 1'b1;
    bus.abort = 1'b1;
    #1;
    checks++;
    if (bus.host_clr !== 1'b0) begin
      errors++; $display("FAIL abort_push_clr: host_clr=%b, expected 0", bus.host_clr);
    end
    tick();
    bus.host_vld = 1'b0;
    bus.abort = 1'b0;
    checks++;
    if (bus.q_cnt !== 0 || bus.send_resp !== 1'b0) begin
      errors++; $display("FAIL abort_push_drop: cnt=%0d sr=%b, expected 0 0", bus.q_cnt, bus.send_resp);
    end
    push_cmd(16'h4555, ok);
    serve(got, ok, sr, rv);
    checks++;
    if (!ok || got !== 16'h4555 || sr !== 1'b1 || rv !== 8'hA5) begin
      errors++; $display("FAIL abort_resume: ok=%b cmd=%h sr=%b resp=%h, expected 1 4555 1 a5", ok, got, sr, rv);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    push_cmd(16'h5001, ok);
    push_cmd(16'h5002, ok);
    wait_rdy(ok);
    rst_n = 1'b0;
    tick();
    checks++;
    if (bus.cmd_rdy !== 1'b0 || bus.q_cnt !== 0 || bus.busy !== 1'b0 || bus.cmd !== 16'h0000) begin
      errors++; $display("FAIL reset_mid: rdy=%b cnt=%0d busy=%b cmd=%h, expected 0 0 0 0000", bus.cmd_rdy, bus.q_cnt, bus.busy, bus.cmd);
    end
    rst_n = 1'b1;
    repeat (3) tick();
    checks++;
    if (bus.cmd_rdy !== 1'b0 || bus.q_cnt !== 0) begin
      errors++; $display("FAIL reset_mid_after: rdy=%b cnt=%0d, expected 0 0", bus.cmd_rdy, bus.q_cnt);
    end
  endtask

`ifdef CMD_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    int k;
    do_reset();
    for (int i = 0; i < 3; i++) push_cmd(16'h6000 + 16'(i), ok);
    wait_rdy(ok);
    bus.clr_cmd_rdy = 1'b1;
    tick();
    bus.clr_cmd_rdy = 1'b0;
    k = 0;
    for (int i = 1; i <= TMO + 100; i++) begin
      tick();
      if (bus.send_resp) begin
        k = i;
        break;
      end
    end
    checks++;
    if (k != TMO || bus.resp !== 8'hEE || bus.q_cnt !== 0) begin
      errors++; $display("FAIL timeout: fired after %0d cycles resp=%h cnt=%0d, expected %0d ee 0", k, bus.resp, bus.q_cnt, TMO);
    end
  endtask
`endif

  initial begin
    idle_inputs();
    test_reset();
    test_single();
    test_back_to_back();
    test_push_pop_wrap();
    test_abort();
    test_reset_mid();
`ifdef CMD_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
